// File: rtl/red_pitaya_dsp_router.sv
// red_pitaya_dsp_router
//   Parametrised signal router and DAC summing stage for the DSP section.
//   - Per consumer d: dst_o[d] = sig_i[input_select[d]] (0 for NONE or any
//     code >= NSIG), registered with one cycle of latency.
//   - Per DAC c: every direct output s whose output_select[s][c] is set is
//     summed in a registered pairwise adder tree, then saturated to W bits.
//     Latency from dir_i to dac_o is L+2 cycles, where L = ceil(log2(NSRC)).
//   - Live and sticky (write-1-to-clear) saturation status on the system bus.
// Optional build macro: DSP_ROUTER_SATCNT_EN adds a 16-bit saturating
//   saturation-cycle counter per DAC at 0x420+4c (any write clears it).
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   sig_i  [NSIG*W]      routable sources, slot k = [k*W +: W]
//   dst_o  [NDST*W]      routed signal per consumer
//   dir_i  [NSRC*W]      direct outputs to be summed
//   dac_o  [NDAC*W]      saturated DAC sums
//   sat_o  [NDAC]        live saturation flag, aligned with dac_o
//   sys_*                system bus (ack/err one cycle after a strobe)
module red_pitaya_dsp_router #(
    parameter int NSIG = 16,
    parameter int LSEL = 5,
    parameter int NDST = 12,
    parameter int NSRC = 10,
    parameter int NDAC = 2,
    parameter int W    = 14
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [NSIG*W-1:0]    sig_i,
    output logic [NDST*W-1:0]    dst_o,
    input  logic [NSRC*W-1:0]    dir_i,
    output logic [NDAC*W-1:0]    dac_o,
    output logic [NDAC-1:0]      sat_o,
    input  logic [31:0]          sys_addr,
    input  logic [31:0]          sys_wdata,
    input  logic                 sys_wen,
    input  logic                 sys_ren,
    output logic [31:0]          sys_rdata,
    output logic                 sys_ack,
    output logic                 sys_err
);
    localparam int L     = $clog2(NSRC);
    localparam int NLEAF = 2**L;
    localparam int SW    = W + L;   // wide enough that the tree never wraps
    localparam logic [LSEL-1:0]        SEL_NONE = '1;
    localparam logic signed [SW-1:0]   SMAX     = $signed(SW'((2**(W-1)) - 1));
    localparam logic signed [SW-1:0]   SMIN     = ~SMAX;
    localparam logic [31:0]            ID_WORD  = {8'(NSIG), 8'(NDST), 8'(NSRC), 8'(NDAC)};

    logic [LSEL-1:0] in_sel_reg  [NDST];
    logic [NDAC-1:0] out_sel_reg [NSRC];
    logic [NDAC-1:0] sticky_reg;
    logic [W-1:0]    dst_reg     [NDST];
    logic [W-1:0]    sig_arr     [2**LSEL];
    logic [11:0]     off;
    logic            strobe;
    logic            rd_hit;
    logic [31:0]     rd_val;
    logic [NDAC-1:0] sticky_clr;
    logic            unused_bits;

    assign off         = sys_addr[11:0];
    assign strobe      = sys_wen | sys_ren;
    assign unused_bits = ^{sys_addr[31:12], sys_wdata};

    // ---------------- routing ----------------
    // Codes at or above NSIG (including NONE) select a hard zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2**LSEL; gi++) begin : g_src
            if (gi < NSIG) begin : g_used
                assign sig_arr[gi] = sig_i[gi*W +: W];
            end else begin : g_zero
                assign sig_arr[gi] = '0;
            end
        end
        for (gi = 0; gi < NDST; gi++) begin : g_dst
            assign dst_o[gi*W +: W] = dst_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int d = 0; d < NDST; d++) dst_reg[d] <= '0;
        end else begin
            for (int d = 0; d < NDST; d++) dst_reg[d] <= sig_arr[in_sel_reg[d]];
        end
    end

    // ---------------- summation ----------------
    // Heap-ordered tree: leaves at NLEAF..2*NLEAF-1, node i sums 2i and 2i+1,
    // root at 1. Every node is a register, so depth is exactly L levels.
    generate
        for (gi = 0; gi < NDAC; gi++) begin : g_dac
            logic signed [SW-1:0] term      [NLEAF];
            logic signed [SW-1:0] node_reg  [1:2*NLEAF-1];
            logic signed [SW-1:0] root;
            logic [W-1:0]         dac_reg;
            logic                 sat_reg;

            always_comb begin
                for (int s = 0; s < NLEAF; s++) term[s] = '0;
                for (int s = 0; s < NSRC; s++)
                    if (out_sel_reg[s][gi]) term[s] = SW'($signed(dir_i[s*W +: W]));
            end

            assign root = node_reg[1];

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    for (int i = 1; i < 2*NLEAF; i++) node_reg[i] <= '0;
                    dac_reg <= '0;
                    sat_reg <= 1'b0;
                end else begin
                    for (int s = 0; s < NLEAF; s++) node_reg[NLEAF+s] <= term[s];
                    for (int i = 1; i < NLEAF; i++) node_reg[i] <= node_reg[2*i] + node_reg[2*i+1];
                    if (root > SMAX) begin
                        dac_reg <= SMAX[W-1:0];
                        sat_reg <= 1'b1;
                    end else if (root < SMIN) begin
                        dac_reg <= SMIN[W-1:0];
                        sat_reg <= 1'b1;
                    end else begin
                        dac_reg <= root[W-1:0];
                        sat_reg <= 1'b0;
                    end
                end
            end

            assign dac_o[gi*W +: W] = dac_reg;
            assign sat_o[gi]        = sat_reg;
        end
    endgenerate

`ifdef DSP_ROUTER_SATCNT_EN
    logic [15:0] cnt_reg [NDAC];
`endif

    // ---------------- bus decode ----------------
    always_comb begin
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NDST; i++)
            if (off == 12'(4*i)) begin
                rd_hit = 1'b1;
                rd_val = 32'(in_sel_reg[i]);
            end
        for (int i = 0; i < NSRC; i++)
            if (off == 12'(12'h200 + 4*i)) begin
                rd_hit = 1'b1;
                rd_val = 32'(out_sel_reg[i]);
            end
        if (off == 12'h400) begin
            rd_hit = 1'b1;
            rd_val = 32'(sticky_reg);
        end
        if (off == 12'h404) begin
            rd_hit = 1'b1;
            rd_val = 32'(sat_o);
        end
        if (off == 12'h408) begin
            rd_hit = 1'b1;
            rd_val = ID_WORD;
        end
`ifdef DSP_ROUTER_SATCNT_EN
        for (int i = 0; i < NDAC; i++)
            if (off == 12'(12'h420 + 4*i)) begin
                rd_hit = 1'b1;
                rd_val = 32'(cnt_reg[i]);
            end
`endif
    end

    assign sticky_clr = (sys_wen && off == 12'h400) ? sys_wdata[NDAC-1:0] : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NDST; i++) in_sel_reg[i] <= SEL_NONE;
            for (int i = 0; i < NSRC; i++) out_sel_reg[i] <= '0;
            sticky_reg <= '0;
            sys_ack    <= 1'b0;
            sys_err    <= 1'b0;
            sys_rdata  <= '0;
        end else begin
            // Reads see the pre-write register contents, so a combined
            // read/write strobe returns the old value.
            sys_ack   <= strobe;
            sys_err   <= strobe & ~rd_hit;
            sys_rdata <= (strobe && rd_hit) ? rd_val : 32'd0;
            if (sys_wen) begin
                for (int i = 0; i < NDST; i++)
                    if (off == 12'(4*i)) in_sel_reg[i] <= sys_wdata[LSEL-1:0];
                for (int i = 0; i < NSRC; i++)
                    if (off == 12'(12'h200 + 4*i)) out_sel_reg[i] <= sys_wdata[NDAC-1:0];
            end
            // Set has priority over a simultaneous clear.
            sticky_reg <= (sticky_reg & ~sticky_clr) | sat_o;
        end
    end

`ifdef DSP_ROUTER_SATCNT_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NDAC; i++) cnt_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NDAC; i++) begin
                if (sys_wen && off == 12'(12'h420 + 4*i))
                    cnt_reg[i] <= '0;
                else if (sat_o[i] && cnt_reg[i] != 16'hFFFF)
                    cnt_reg[i] <= cnt_reg[i] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_red_pitaya_dsp_router.sv
// Directed testbench for red_pitaya_dsp_router with default parameters.
module tb_red_pitaya_dsp_router;
    localparam int NSIG = 16;
    localparam int LSEL = 5;
    localparam int NDST = 12;
    localparam int NSRC = 10;
    localparam int NDAC = 2;
    localparam int W    = 14;

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic [NSIG*W-1:0]    sig_i;
    logic [NDST*W-1:0]    dst_o;
    logic [NSRC*W-1:0]    dir_i;
    logic [NDAC*W-1:0]    dac_o;
    logic [NDAC-1:0]      sat_o;
    logic [31:0]          sys_addr;
    logic [31:0]          sys_wdata;
    logic                 sys_wen;
    logic                 sys_ren;
    logic [31:0]          sys_rdata;
    logic                 sys_ack;
    logic                 sys_err;

    int n_checks = 0;
    int n_errors = 0;

    red_pitaya_dsp_router #(
        .NSIG(NSIG), .LSEL(LSEL), .NDST(NDST), .NSRC(NSRC), .NDAC(NDAC), .W(W)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .sig_i     (sig_i),
        .dst_o     (dst_o),
        .dir_i     (dir_i),
        .dac_o     (dac_o),
        .sat_o     (sat_o),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_wen   (sys_wen),
        .sys_ren   (sys_ren),
        .sys_rdata (sys_rdata),
        .sys_ack   (sys_ack),
        .sys_err   (sys_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_xfer(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] rd, output logic er);
        @(posedge clk_i);
        #1;
        sys_addr  = a;
        sys_wdata = d;
        sys_wen   = we;
        sys_ren   = re;
        @(posedge clk_i);
        #1;
        sys_wen = 1'b0;
        sys_ren = 1'b0;
        rd = sys_rdata;
        er = sys_err;
        check_val("ack", 32'(sys_ack), 32'd1);
    endtask

    task automatic bus_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err);
        logic [31:0] rd;
        logic        er;
        bus_xfer(1'b1, 1'b0, a, d, rd, er);
        check_val({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                          input logic exp_err);
        logic [31:0] rd;
        logic        er;
        bus_xfer(1'b0, 1'b1, a, 32'd0, rd, er);
        check_val(tag, rd, exp);
        check_val({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    task automatic set_dir(input int idx, input logic [W-1:0] v);
        dir_i[idx*W +: W] = v;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        rstn_i    = 1'b0;
        sig_i     = '0;
        dir_i     = '0;
        sys_addr  = '0;
        sys_wdata = '0;
        sys_wen   = 1'b0;
        sys_ren   = 1'b0;

        // Reset state
        wait_cyc(3);
        check_val("rst_dac", 32'(dac_o), 32'd0);
        check_val("rst_dst_any", 32'(|dst_o), 32'd0);
        check_val("rst_sat", 32'(sat_o), 32'd0);
        check_val("rst_ack", 32'(sys_ack), 32'd0);
        check_val("rst_err", 32'(sys_err), 32'd0);
        check_val("rst_rdata", sys_rdata, 32'd0);
        rstn_i = 1'b1;
        bus_rd("id", 32'h408, 32'h100C0A02, 1'b0);
        bus_rd("sticky0", 32'h400, 32'd0, 1'b0);
        bus_rd("insel3_rst", 32'h00C, 32'h1F, 1'b0);
        bus_rd("outsel0_rst", 32'h200, 32'd0, 1'b0);
        wait_cyc(1);
        check_val("ack_drop", 32'(sys_ack), 32'd0);

        // Routing
        sig_i[5*W +: W]  = 14'h1234;
        sig_i[15*W +: W] = 14'h2AAA;
        bus_wr("wr_insel3", 32'h00C, 32'd5, 1'b0);
        wait_cyc(1);
        check_val("dst3_sel5", 32'(dst_o[3*W +: W]), 32'h1234);
        check_val("dst0_none", 32'(dst_o[0*W +: W]), 32'h0);
        bus_wr("wr_insel3", 32'h00C, 32'd15, 1'b0);
        wait_cyc(1);
        check_val("dst3_sel15", 32'(dst_o[3*W +: W]), 32'h2AAA);
        bus_wr("wr_insel3", 32'h00C, 32'd16, 1'b0);
        wait_cyc(1);
        check_val("dst3_sel16", 32'(dst_o[3*W +: W]), 32'h0);
        bus_wr("wr_insel3", 32'h00C, 32'd5, 1'b0);
        bus_wr("wr_insel3", 32'h00C, 32'd31, 1'b0);
        wait_cyc(1);
        check_val("dst3_sel31", 32'(dst_o[3*W +: W]), 32'h0);
        bus_rd("insel3_rb", 32'h00C, 32'h1F, 1'b0);
        bus_wr("wr_insel1", 32'h004, 32'hFFFF_FFE5, 1'b0);
        bus_rd("insel1_rb", 32'h004, 32'h05, 1'b0);
        wait_cyc(1);
        check_val("dst1_sel5", 32'(dst_o[1*W +: W]), 32'h1234);

        // Summation and latency
        bus_wr("wr_outsel0", 32'h200, 32'd1, 1'b0);
        bus_wr("wr_outsel1", 32'h204, 32'd3, 1'b0);
        set_dir(0, 14'd100);
        set_dir(1, 14'h3FD8);   // -40
        wait_cyc(7);
        check_val("dac0_60", 32'(dac_o[0 +: W]), 32'h3C);
        check_val("dac1_m40", 32'(dac_o[W +: W]), 32'h3FD8);
        check_val("sat_none", 32'(sat_o), 32'd0);
        set_dir(0, 14'd200);
        wait_cyc(5);
        check_val("dac0_lat5_old", 32'(dac_o[0 +: W]), 32'h3C);
        wait_cyc(1);
        check_val("dac0_lat6_new", 32'(dac_o[0 +: W]), 32'hA0);
        check_val("dac1_lat6", 32'(dac_o[W +: W]), 32'h3FD8);

        // Saturation boundary
        for (int k = 0; k < 4; k++) bus_wr("wr_outsel", 32'h200 + 32'(4*k), 32'd1, 1'b0);
        set_dir(0, 14'h1FFF);
        set_dir(1, 14'h0);
        wait_cyc(7);
        check_val("dac0_max", 32'(dac_o[0 +: W]), 32'h1FFF);
        check_val("sat_at_max", 32'(sat_o), 32'd0);
        check_val("dac1_unmasked", 32'(dac_o[W +: W]), 32'h0);
        bus_rd("sticky_clean", 32'h400, 32'd0, 1'b0);
        set_dir(1, 14'd1);
        wait_cyc(7);
        check_val("dac0_max_plus1", 32'(dac_o[0 +: W]), 32'h1FFF);
        check_val("sat_max_plus1", 32'(sat_o), 32'd1);
        for (int k = 0; k < 4; k++) set_dir(k, 14'h1FFF);
        wait_cyc(7);
        check_val("dac0_pos_sat", 32'(dac_o[0 +: W]), 32'h1FFF);
        check_val("sat_pos", 32'(sat_o), 32'd1);
        bus_rd("live_sat", 32'h404, 32'd1, 1'b0);
        bus_rd("sticky_set", 32'h400, 32'd1, 1'b0);
        bus_wr("w1c_during", 32'h400, 32'd1, 1'b0);
        bus_rd("sticky_hold", 32'h400, 32'd1, 1'b0);
        for (int k = 0; k < 4; k++) set_dir(k, 14'h2000);
        wait_cyc(7);
        check_val("dac0_neg_sat", 32'(dac_o[0 +: W]), 32'h2000);
        check_val("sat_neg", 32'(sat_o), 32'd1);
        dir_i = '0;
        wait_cyc(7);
        check_val("sat_clear", 32'(sat_o), 32'd0);
        check_val("dac0_zero", 32'(dac_o[0 +: W]), 32'h0);
        bus_rd("sticky_kept", 32'h400, 32'd1, 1'b0);
        bus_wr("w1c", 32'h400, 32'd1, 1'b0);
        bus_rd("sticky_cleared", 32'h400, 32'd0, 1'b0);

        // Errors and address aliasing
        bus_rd("rd_230", 32'h230, 32'd0, 1'b1);
        bus_wr("wr_230", 32'h230, 32'hFFFF_FFFF, 1'b1);
        for (int k = 0; k < 4; k++) bus_rd("outsel_keep", 32'h200 + 32'(4*k), 32'd1, 1'b0);
        bus_rd("outsel9_keep", 32'h224, 32'd0, 1'b0);
        bus_rd("rd_40c", 32'h40C, 32'd0, 1'b1);
        bus_rd("rd_030", 32'h030, 32'd0, 1'b1);
        bus_rd("alias_ff00c", 32'h000F_F00C, 32'h1F, 1'b0);

        // Simultaneous write and read returns the old value
        bus_xfer(1'b1, 1'b1, 32'h00C, 32'd7, rd, er);
        check_val("rw_old", rd, 32'h1F);
        check_val("rw_err", 32'(er), 32'd0);
        bus_rd("rw_new", 32'h00C, 32'd7, 1'b0);

`ifdef DSP_ROUTER_SATCNT_EN
        bus_wr("cnt_clr", 32'h420, 32'd0, 1'b0);
        bus_rd("cnt0_zero", 32'h420, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) set_dir(k, 14'h1FFF);
        wait_cyc(3);
        dir_i = '0;
        wait_cyc(10);
        bus_rd("cnt0_three", 32'h420, 32'd3, 1'b0);
        bus_rd("cnt1_zero", 32'h424, 32'd0, 1'b0);
        bus_wr("cnt_clr2", 32'h420, 32'd0, 1'b0);
        bus_rd("cnt0_cleared", 32'h420, 32'd0, 1'b0);
`else
        bus_rd("cnt_unmapped", 32'h420, 32'd0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
